// File: rtl/addsub_ctrl.sv
// Initiator for the FP add/sub start/done handshake with a timeout and a response FIFO.
// Optional ADDSUB_CTRL_STATS_EN adds saturating stat_ops/stat_ovf counters.
//
// state  | meaning
// IDLE   | ready for a host request when the response FIFO has room
// ISSUE  | one-cycle add_start pulse, timer cleared
// WAIT   | waiting for add_done; abandoned after TIMEOUT cycles
module addsub_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic        req_mode,
    output logic        add_start,
    output logic        mode,
    output logic [31:0] op1,
    output logic [31:0] op2,
    input  logic [31:0] add_result,
    input  logic        add_done,
    input  logic        add_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_timeout
`ifdef ADDSUB_CTRL_STATS_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_ovf
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic [31:0] mem_result [DEPTH];
    logic        mem_ovf    [DEPTH];
    logic        mem_to     [DEPTH];

    logic        push;
    logic        pop;
    logic [31:0] push_result;
    logic        push_ovf;
    logic        push_to;

    // done takes priority over expiry when both land in the same cycle
    always_comb begin
        push        = 1'b0;
        push_result = 32'h0;
        push_ovf    = 1'b0;
        push_to     = 1'b0;
        if (state == S_WAIT) begin
            if (add_done) begin
                push        = 1'b1;
                push_result = add_result;
                push_ovf    = add_overflow;
            end else if (timer == TW'(TIMEOUT - 1)) begin
                push    = 1'b1;
                push_to = 1'b1;
            end
        end
    end

    assign rsp_valid    = (count != '0);
    assign pop          = rsp_valid && rsp_ready;
    assign req_ready    = (state == S_IDLE) && (count < CW'(DEPTH));
    assign rsp_result   = mem_result[rd_ptr];
    assign rsp_overflow = mem_ovf[rd_ptr];
    assign rsp_timeout  = mem_to[rd_ptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            add_start <= 1'b0;
            op1       <= 32'h0;
            op2       <= 32'h0;
            mode      <= 1'b0;
            timer     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    add_start <= 1'b0;
                    if (req_valid && req_ready) begin
                        op1       <= req_op1;
                        op2       <= req_op2;
                        mode      <= req_mode;
                        add_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    add_start <= 1'b0;
                    timer     <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    add_start <= 1'b0;
                    if (push) begin
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    add_start <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset: the empty count masks stale entries
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= push_result;
            mem_ovf[wr_ptr]    <= push_ovf;
            mem_to[wr_ptr]     <= push_to;
        end
    end

`ifdef ADDSUB_CTRL_STATS_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stat_ops <= 16'h0;
            stat_ovf <= 16'h0;
        end else if (push) begin
            if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            if (push_ovf && stat_ovf != 16'hFFFF) stat_ovf <= stat_ovf + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_addsub_ctrl.sv
// Self-checking bench for addsub_ctrl: bench-side unit model plus response scoreboard.
module tb_addsub_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 99;

    logic        clk;
    logic        n_rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic        req_mode;
    logic        add_start;
    logic        mode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] add_result;
    logic        add_done;
    logic        add_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_overflow;
    logic        rsp_timeout;
`ifdef ADDSUB_CTRL_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_ovf;
    int          m_ops;
    int          m_ovf;
`endif

    addsub_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .req_mode     (req_mode),
        .add_start    (add_start),
        .mode         (mode),
        .op1          (op1),
        .op2          (op2),
        .add_result   (add_result),
        .add_done     (add_done),
        .add_overflow (add_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_timeout  (rsp_timeout)
`ifdef ADDSUB_CTRL_STATS_EN
        ,
        .stat_ops     (stat_ops),
        .stat_ovf     (stat_ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] r;
        logic        o;
        logic        t;
    } rsp_t;

    int ntests = 0;
    int nfail  = 0;

    // per-op plan for the unit model: done after dly WAIT cycles (>=TIMEOUT means never)
    int          plan_dly [64];
    logic [31:0] plan_res [64];
    logic        plan_ovf [64];
    int          n_acc  = 0;
    int          u_idx  = 0;
    int          nstart = 0;
    rsp_t        exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // unit model + scoreboard, evaluated once per cycle at the falling edge
    initial begin : model
        bit          busy;
        bit          prev_start;
        int          wcnt;
        int          cur;
        logic [31:0] c_op1;
        logic [31:0] c_op2;
        logic        c_mode;
        rsp_t        e;
        busy = 0;
        prev_start = 0;
        wcnt = 0;
        cur = 0;
        c_op1 = '0;
        c_op2 = '0;
        c_mode = 1'b0;
        forever begin
            @(negedge clk);
            add_done     = 1'b0;
            add_overflow = 1'b0;
            add_result   = 32'h0;
            if (!n_rst) begin
                exp_q.delete();
                busy = 0;
                prev_start = 0;
`ifdef ADDSUB_CTRL_STATS_EN
                m_ops = 0;
                m_ovf = 0;
`endif
            end else begin
                chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_q.size() != 0});
                if (exp_q.size() != 0) begin
                    chk("rsp_result", rsp_result, exp_q[0].r);
                    chk("rsp_overflow", {31'b0, rsp_overflow}, {31'b0, exp_q[0].o});
                    chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, exp_q[0].t});
                    if (rsp_ready) void'(exp_q.pop_front());
                end
                if (add_start && prev_start) chk("start_pulse_len", 32'd2, 32'd1);
                prev_start = add_start;
                if (busy) begin
                    chk("op1_stable", op1, c_op1);
                    chk("op2_stable", op2, c_op2);
                    chk("mode_stable", {31'b0, mode}, {31'b0, c_mode});
                    if (wcnt == plan_dly[cur]) begin
                        add_done     = 1'b1;
                        add_result   = plan_res[cur];
                        add_overflow = plan_ovf[cur];
                        e.r = plan_res[cur];
                        e.o = plan_ovf[cur];
                        e.t = 1'b0;
                        exp_q.push_back(e);
                        busy = 0;
                    end else if (wcnt == TIMEOUT - 1) begin
                        e.r = 32'h0;
                        e.o = 1'b0;
                        e.t = 1'b1;
                        exp_q.push_back(e);
                        busy = 0;
                    end
`ifdef ADDSUB_CTRL_STATS_EN
                    if (!busy) begin
                        m_ops++;
                        if (e.o) m_ovf++;
                    end
`endif
                    wcnt++;
                end
                if (add_start) begin
                    nstart++;
                    busy   = 1;
                    wcnt   = 0;
                    cur    = u_idx;
                    u_idx++;
                    c_op1  = op1;
                    c_op2  = op2;
                    c_mode = mode;
                end
            end
        end
    end

    task automatic set_plan(input int dly, input logic [31:0] res, input logic ovf);
        plan_dly[n_acc] = dly;
        plan_res[n_acc] = res;
        plan_ovf[n_acc] = ovf;
    endtask

    // presents a request and returns at posedge+1 of the cycle after the accept edge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic m,
                        input int dly, input logic [31:0] res, input logic ovf);
        int k;
        set_plan(dly, res, ovf);
        req_op1   = a;
        req_op2   = b;
        req_mode  = m;
        req_valid = 1'b1;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (k == 100) chk("accept_timeout", 32'd0, 32'd1);
        tick();
        req_valid = 1'b0;
        n_acc++;
    endtask

    initial begin : stim
        int s0;
        n_rst     = 1'b0;
        req_valid = 1'b0;
        req_op1   = '0;
        req_op2   = '0;
        req_mode  = 1'b0;
        rsp_ready = 1'b0;
        add_done     = 1'b0;
        add_overflow = 1'b0;
        add_result   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_add_start", {31'b0, add_start}, 32'd0);
        chk("rst_op1", op1, 32'h0);
        chk("rst_op2", op2, 32'h0);
        chk("rst_mode", {31'b0, mode}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        tick();

        // 1: basic latency, 1.25 + 1.5 = 2.75
        send(32'h3FA00000, 32'h3FC00000, 1'b0, 0, 32'h40300000, 1'b0);
        chk("t1_start_c1", {31'b0, add_start}, 32'd1);
        chk("t1_op1", op1, 32'h3FA00000);
        chk("t1_op2", op2, 32'h3FC00000);
        tick();
        chk("t1_start_c2", {31'b0, add_start}, 32'd0);
        chk("t1_valid_c2", {31'b0, rsp_valid}, 32'd0);
        tick();
        chk("t1_valid_c3", {31'b0, rsp_valid}, 32'd1);
        chk("t1_result", rsp_result, 32'h40300000);
        chk("t1_ovf", {31'b0, rsp_overflow}, 32'd0);
        chk("t1_to", {31'b0, rsp_timeout}, 32'd0);
        chk("t1_nstart", nstart, 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 2: fill FIFO, stall, one pop reopens, in-order drain
        for (int i = 0; i < 4; i++)
            send(32'h1000 + i, 32'h2000 + i, i[0], 0, 32'hA0000000 + i, 1'b0);
        chk("t2_ready_issue", {31'b0, req_ready}, 32'd0);
        repeat (3) tick();
        chk("t2_ready_full", {31'b0, req_ready}, 32'd0);
        chk("t2_head", rsp_result, 32'hA0000000);
        s0 = nstart;
        set_plan(0, 32'hA0000004, 1'b1);
        req_op1   = 32'h1004;
        req_op2   = 32'h2004;
        req_mode  = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_stall", {31'b0, req_ready}, 32'd0);
        end
        chk("t2_no_start", nstart, s0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t2_ready_after_pop", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        n_acc++;
        chk("t2_5th_start", {31'b0, add_start}, 32'd1);
        rsp_ready = 1'b1;
        repeat (12) tick();
        chk("t2_drained", {31'b0, rsp_valid}, 32'd0);
        chk("t2_q_empty", exp_q.size(), 32'd0);
        rsp_ready = 1'b0;

        // 3: timeout after 16 WAIT cycles, then done exactly at expiry
        send(32'h3F800000, 32'h3F800000, 1'b1, NEVER, 32'hDEADBEEF, 1'b0);
        repeat (16) tick();
        chk("t3_to_c17", {31'b0, rsp_valid}, 32'd0);
        tick();
        chk("t3_to_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t3_to_result", rsp_result, 32'h0);
        chk("t3_to_flag", {31'b0, rsp_timeout}, 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        send(32'h40000000, 32'h40000000, 1'b0, TIMEOUT - 1, 32'h40800000, 1'b0);
        repeat (16) tick();
        chk("t3_edge_c17", {31'b0, rsp_valid}, 32'd0);
        tick();
        chk("t3_edge_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t3_edge_result", rsp_result, 32'h40800000);
        chk("t3_edge_to", {31'b0, rsp_timeout}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 4: overflow, operands held through WAIT
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 2, 32'h7F800000, 1'b1);
        tick();
        chk("t4_op1_wait", op1, 32'h7F7FFFFF);
        chk("t4_mode_wait", {31'b0, mode}, 32'd1);
        repeat (3) tick();
        chk("t4_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t4_ovf", {31'b0, rsp_overflow}, 32'd1);
        chk("t4_result", rsp_result, 32'h7F800000);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 5: reset during WAIT with two responses queued
        send(32'h1, 32'h2, 1'b0, 0, 32'hB0000001, 1'b0);
        send(32'h3, 32'h4, 1'b0, 0, 32'hB0000002, 1'b0);
        send(32'h5, 32'h6, 1'b1, NEVER, 32'hB0000003, 1'b0);
        repeat (3) tick();
        chk("t5_queued", exp_q.size(), 32'd2);
        n_rst = 1'b0;
        #1;
        chk("t5_rst_start", {31'b0, add_start}, 32'd0);
        chk("t5_rst_valid", {31'b0, rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        chk("t5_ready", {31'b0, req_ready}, 32'd1);
        chk("t5_valid_rel", {31'b0, rsp_valid}, 32'd0);
        rsp_ready = 1'b1;
        repeat (25) tick();
        chk("t5_no_stale", {31'b0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;
        send(32'h3FA00000, 32'h3FC00000, 1'b0, 1, 32'h40300000, 1'b0);
        repeat (3) tick();
        chk("t5_recover", rsp_result, 32'h40300000);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

`ifdef ADDSUB_CTRL_STATS_EN
        // 6: counters after reset: 3 ops, one overflow, one timeout (recovery op counted too)
        send(32'h1, 32'h1, 1'b0, 0, 32'h11, 1'b1);
        send(32'h2, 32'h2, 1'b0, NEVER, 32'h22, 1'b0);
        rsp_ready = 1'b1;
        repeat (20) tick();
        chk("t6_stat_ops", stat_ops, 32'd3);
        chk("t6_stat_ovf", stat_ovf, 32'd1);
        chk("t6_model_ops", stat_ops, m_ops);
        chk("t6_model_ovf", stat_ovf, m_ovf);
        rsp_ready = 1'b0;
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
